// File: rtl/ghash_pkg.sv
// Shared constants for the GHASH datapath: block width and multiplier result
// destination selects.
package ghash_pkg;

    localparam int unsigned GHASH_W = 128;

    localparam logic [1:0] SEL_Y   = 2'b00;
    localparam logic [1:0] SEL_H   = 2'b01;
    localparam logic [1:0] SEL_TAG = 2'b10;
    localparam logic [1:0] SEL_BAD = 2'b11;

endpackage

// File: rtl/ghash_demux_slot.sv
// One-entry output buffer for the GHASH result demux: data register, valid
// flag, accepted-beat counter and the "can take a beat" term for in_ready.
module ghash_demux_slot #(
    parameter int unsigned WIDTH = 128,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    output logic             can_take,
    output logic [WIDTH-1:0] data,
    output logic             valid,
    input  logic             ready,
    output logic [CNT_W-1:0] cnt
);

    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             accept;

    // A full slot can still take a beat when its consumer drains it this cycle.
    assign can_take = !valid_q || ready;
    assign accept   = push && can_take;

    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        cnt_d   = cnt_q;
        if (accept) begin
            data_d  = push_data;
            valid_d = 1'b1;
            cnt_d   = cnt_q + CNT_W'(1);
        end else if (valid_q && ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

    assign data  = data_q;
    assign valid = valid_q;
    assign cnt   = cnt_q;

endmodule

// File: rtl/ghash_demux.sv
// Steers GF(2^128) multiplier results to the Y accumulator, H-power register
// or tag path through three one-entry buffered slots.
module ghash_demux
    import ghash_pkg::*;
#(
    parameter int unsigned WIDTH = GHASH_W,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       in_sel,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out1_data,
    output logic             out1_valid,
    input  logic             out1_ready,
    output logic [WIDTH-1:0] out2_data,
    output logic             out2_valid,
    input  logic             out2_ready,
    output logic [WIDTH-1:0] out3_data,
    output logic             out3_valid,
    input  logic             out3_ready,
    output logic [CNT_W-1:0] cnt1,
    output logic [CNT_W-1:0] cnt2,
    output logic [CNT_W-1:0] cnt3,
    output logic             err_sel,
    output logic [CNT_W-1:0] err_cnt
);

    logic push1, push2, push3;
    logic can1, can2, can3;
    logic bad_accept;
    logic             err_sel_q;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

    assign push1 = in_valid && (in_sel == SEL_Y);
    assign push2 = in_valid && (in_sel == SEL_H);
    assign push3 = in_valid && (in_sel == SEL_TAG);

    // Illegal beats are always consumed, so the handshake is just in_valid.
    assign bad_accept = in_valid && (in_sel == SEL_BAD);

    always_comb begin
        in_ready = 1'b1;
        unique case (in_sel)
            SEL_Y:   in_ready = can1;
            SEL_H:   in_ready = can2;
            SEL_TAG: in_ready = can3;
            SEL_BAD: in_ready = 1'b1;
        endcase
    end

    ghash_demux_slot #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_slot_y (
        .clk       (clk),
        .rst       (rst),
        .push      (push1),
        .push_data (in_data),
        .can_take  (can1),
        .data      (out1_data),
        .valid     (out1_valid),
        .ready     (out1_ready),
        .cnt       (cnt1)
    );

    ghash_demux_slot #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_slot_h (
        .clk       (clk),
        .rst       (rst),
        .push      (push2),
        .push_data (in_data),
        .can_take  (can2),
        .data      (out2_data),
        .valid     (out2_valid),
        .ready     (out2_ready),
        .cnt       (cnt2)
    );

    ghash_demux_slot #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_slot_tag (
        .clk       (clk),
        .rst       (rst),
        .push      (push3),
        .push_data (in_data),
        .can_take  (can3),
        .data      (out3_data),
        .valid     (out3_valid),
        .ready     (out3_ready),
        .cnt       (cnt3)
    );

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (bad_accept) begin
            err_cnt_d = err_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_sel_q <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            err_sel_q <= bad_accept;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_sel = err_sel_q;
    assign err_cnt = err_cnt_q;

endmodule

// File: tb/tb_ghash_demux.sv
// Directed self-checking bench for ghash_demux: a default instance for routing,
// backpressure and error checks, plus a CNT_W = 4 instance for counter wrap.
module tb_ghash_demux;

    localparam int unsigned W = 128;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] in_data;
    logic [1:0]   in_sel;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] out1_data, out2_data, out3_data;
    logic         out1_valid, out2_valid, out3_valid;
    logic         out1_ready, out2_ready, out3_ready;
    logic [15:0]  cnt1, cnt2, cnt3, err_cnt;
    logic         err_sel;

    logic [W-1:0] w_data;
    logic [1:0]   w_sel;
    logic         w_valid;
    logic         w_in_ready;
    logic [W-1:0] w_out1_data, w_out2_data, w_out3_data;
    logic         w_out1_valid, w_out2_valid, w_out3_valid;
    logic         w_ready;
    logic [3:0]   w_cnt1, w_cnt2, w_cnt3, w_err_cnt;
    logic         w_err_sel;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ghash_demux #(.WIDTH(W), .CNT_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_sel     (in_sel),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out1_data  (out1_data),
        .out1_valid (out1_valid),
        .out1_ready (out1_ready),
        .out2_data  (out2_data),
        .out2_valid (out2_valid),
        .out2_ready (out2_ready),
        .out3_data  (out3_data),
        .out3_valid (out3_valid),
        .out3_ready (out3_ready),
        .cnt1       (cnt1),
        .cnt2       (cnt2),
        .cnt3       (cnt3),
        .err_sel    (err_sel),
        .err_cnt    (err_cnt)
    );

    ghash_demux #(.WIDTH(W), .CNT_W(4)) dut_w (
        .clk        (clk),
        .rst        (rst),
        .in_data    (w_data),
        .in_sel     (w_sel),
        .in_valid   (w_valid),
        .in_ready   (w_in_ready),
        .out1_data  (w_out1_data),
        .out1_valid (w_out1_valid),
        .out1_ready (w_ready),
        .out2_data  (w_out2_data),
        .out2_valid (w_out2_valid),
        .out2_ready (w_ready),
        .out3_data  (w_out3_data),
        .out3_valid (w_out3_valid),
        .out3_ready (w_ready),
        .cnt1       (w_cnt1),
        .cnt2       (w_cnt2),
        .cnt3       (w_cnt3),
        .err_sel    (w_err_sel),
        .err_cnt    (w_err_cnt)
    );

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge; registered outputs are stable here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] s, input logic [W-1:0] d);
        in_valid = v;
        in_sel   = s;
        in_data  = d;
    endtask

    initial begin
        logic [W-1:0] a5;
        a5 = {16{8'hA5}};

        rst = 1'b1;
        drive(1'b0, 2'b00, '0);
        out1_ready = 1'b0; out2_ready = 1'b0; out3_ready = 1'b0;
        w_valid = 1'b0; w_sel = 2'b10; w_data = '0; w_ready = 1'b1;
        #12;
        rst = 1'b0;
        #1;
        chk("rst_out1_valid", out1_valid, 0);
        chk("rst_out1_data", out1_data, 0);
        chk("rst_cnt", {cnt1, cnt2, cnt3, err_cnt}, 0);
        chk("rst_err_sel", err_sel, 0);
        chk("rst_in_ready", in_ready, 1);

        // Reset during traffic
        tick();
        drive(1'b1, 2'b00, a5);
        tick();
        drive(1'b0, 2'b00, '0);
        chk("fill_out1_valid", out1_valid, 1);
        chk("fill_out1_data", out1_data, a5);
        chk("fill_cnt1", cnt1, 1);
        chk("full_in_ready_no_valid", in_ready, 0);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_out1_valid", out1_valid, 0);
        chk("async_rst_out1_data", out1_data, 0);
        chk("async_rst_cnt1", cnt1, 0);
        #2 rst = 1'b0;
        #1;
        chk("post_rst_in_ready", in_ready, 1);

        // Route each select
        tick();
        out1_ready = 1'b1; out2_ready = 1'b1; out3_ready = 1'b1;
        drive(1'b1, 2'b00, 128'h1);
        tick();
        drive(1'b1, 2'b01, 128'h2);
        chk("route_v1", {out1_valid, out2_valid, out3_valid}, 3'b100);
        chk("route_d1", out1_data, 128'h1);
        tick();
        drive(1'b1, 2'b10, 128'h3);
        chk("route_v2", {out1_valid, out2_valid, out3_valid}, 3'b010);
        chk("route_d2", out2_data, 128'h2);
        tick();
        drive(1'b0, 2'b00, '0);
        chk("route_v3", {out1_valid, out2_valid, out3_valid}, 3'b001);
        chk("route_d3", out3_data, 128'h3);
        tick();
        chk("route_v_idle", {out1_valid, out2_valid, out3_valid}, 3'b000);
        chk("route_cnts", {cnt1, cnt2, cnt3}, {16'd1, 16'd1, 16'd1});

        // Backpressure and independence
        out2_ready = 1'b0;
        drive(1'b1, 2'b01, 128'hDEAD);
        #1 chk("bp_ready_empty", in_ready, 1);
        tick();
        drive(1'b1, 2'b01, 128'hBEEF);
        #1 chk("bp_ready_stall", in_ready, 0);
        tick();
        chk("bp_hold_data", out2_data, 128'hDEAD);
        chk("bp_hold_valid", out2_valid, 1);
        chk("bp_cnt2_stalled", cnt2, 2);
        drive(1'b1, 2'b10, 128'hCAFE);
        #1 chk("bp_other_ready", in_ready, 1);
        tick();
        chk("bp_out3_valid", out3_valid, 1);
        chk("bp_out3_data", out3_data, 128'hCAFE);
        chk("bp_out2_still", out2_data, 128'hDEAD);
        drive(1'b1, 2'b01, 128'hBEEF);
        out2_ready = 1'b1;
        #1 chk("bp_ready_drain", in_ready, 1);
        tick();
        drive(1'b0, 2'b00, '0);
        chk("bp_out2_valid", out2_valid, 1);
        chk("bp_out2_data", out2_data, 128'hBEEF);
        chk("bp_cnts", {cnt2, cnt3}, {16'd3, 16'd2});
        tick();
        chk("bp_drained", out2_valid, 0);

        // Full-throughput pass-through from a fresh reset
        rst = 1'b1;
        #2 rst = 1'b0;
        tick();
        for (int i = 0; i < 64; i++) begin
            drive(1'b1, 2'b00, W'(i));
            #1 chk("tp_in_ready", in_ready, 1);
            tick();
            chk("tp_valid", out1_valid, 1);
            chk("tp_data", out1_data, W'(i));
        end
        drive(1'b0, 2'b00, '0);
        tick();
        chk("tp_cnt1", cnt1, 64);
        chk("tp_drained", out1_valid, 0);

        // Illegal select
        out1_ready = 1'b0; out2_ready = 1'b0; out3_ready = 1'b0;
        drive(1'b1, 2'b11, 128'hFF);
        #1 chk("bad_in_ready", in_ready, 1);
        tick();
        drive(1'b0, 2'b00, '0);
        chk("bad_err_sel", err_sel, 1);
        chk("bad_err_cnt", err_cnt, 1);
        chk("bad_no_valid", {out1_valid, out2_valid, out3_valid}, 3'b000);
        chk("bad_cnts", {cnt1, cnt2, cnt3}, {16'd64, 16'd0, 16'd0});
        tick();
        chk("bad_err_sel_pulse", err_sel, 0);
        chk("bad_err_cnt_hold", err_cnt, 1);

        // Counter wrap on the narrow-counter instance
        for (int i = 0; i < 17; i++) begin
            w_valid = 1'b1;
            w_sel   = 2'b10;
            w_data  = W'(i + 100);
            tick();
        end
        w_valid = 1'b0;
        chk("wrap_cnt3", w_cnt3, 1);
        chk("wrap_last_data", w_out3_data, W'(116));
        chk("wrap_no_err", {w_err_sel, w_err_cnt}, 0);
        chk("wrap_other_cnts", {w_cnt1, w_cnt2}, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
